// File: rtl/tb_ahb_mem_slave.sv
// AHB-Lite memory slave standing in for the hmain0 matrix and target SRAM.
// Provides word storage with byte lanes, fixed wait states, two-cycle
// ERROR responses and completion counters.
module tb_ahb_mem_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned WAIT_CYC  = 0
) (
  input  logic        pad_core_clk,
  input  logic        pad_core_rst_b,
  input  logic [31:0] cpu_hmain0_m0_haddr,
  input  logic [2:0]  cpu_hmain0_m0_hburst,
  input  logic [3:0]  cpu_hmain0_m0_hprot,
  input  logic [2:0]  cpu_hmain0_m0_hsize,
  input  logic [1:0]  cpu_hmain0_m0_htrans,
  input  logic [31:0] cpu_hmain0_m0_hwdata,
  input  logic        cpu_hmain0_m0_hwrite,
  output logic [31:0] hmain0_cpu_m0_hrdata,
  output logic        hmain0_cpu_m0_hready,
  output logic [1:0]  hmain0_cpu_m0_hresp,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
  output logic [15:0] err_cnt
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_e;

  logic [31:0]   mem [DEPTH];

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          hready_q;
  logic [1:0]    hresp_q;
  logic [31:0]   hrdata_q;
  logic [15:0]   rd_cnt_q;
  logic [15:0]   wr_cnt_q;
  logic [15:0]   err_cnt_q;
  logic          cur_wr_q;
  logic [AW-1:0] cur_idx_q;
  logic [3:0]    cur_be_q;

  logic [31:0]   offset_c;
  logic          in_range_c;
  logic          align_ok_c;
  logic          legal_c;
  logic          capture_c;
  logic [AW-1:0] idx_c;
  logic [3:0]    be_c;
  logic          commit_c;
  logic [31:0]   wmerge_c;
  logic [31:0]   fwd_rdata_c;
  logic          unused_c;

  assign unused_c = ^{cpu_hmain0_m0_hburst, cpu_hmain0_m0_hprot};

  // Address-phase decode: range, alignment, word index and byte enables
  always_comb begin
    offset_c   = cpu_hmain0_m0_haddr - BASE_ADDR;
    in_range_c = (cpu_hmain0_m0_haddr >= BASE_ADDR) && (offset_c < SPAN);
    idx_c      = offset_c[AW+1:2];
    align_ok_c = 1'b0;
    be_c       = 4'b0000;
    case (cpu_hmain0_m0_hsize)
      3'd0: begin
        align_ok_c = 1'b1;
        be_c       = 4'(4'b0001 << cpu_hmain0_m0_haddr[1:0]);
      end
      3'd1: begin
        align_ok_c = ~cpu_hmain0_m0_haddr[0];
        be_c       = cpu_hmain0_m0_haddr[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        align_ok_c = (cpu_hmain0_m0_haddr[1:0] == 2'b00);
        be_c       = 4'b1111;
      end
      default: begin
        align_ok_c = 1'b0;
        be_c       = 4'b0000;
      end
    endcase
    legal_c   = in_range_c && align_ok_c;
    capture_c = hready_q && cpu_hmain0_m0_htrans[1];
  end

  // Write commit in the completing cycle, with forwarding to an overlapping read
  always_comb begin
    commit_c = (state_q == S_DONE) && cur_wr_q;
    wmerge_c = mem[cur_idx_q];
    for (int i = 0; i < 4; i++) begin
      if (cur_be_q[i]) begin
        wmerge_c[8*i +: 8] = cpu_hmain0_m0_hwdata[8*i +: 8];
      end
    end
    fwd_rdata_c = (commit_c && (cur_idx_q == idx_c)) ? wmerge_c : mem[idx_c];
  end

  // Storage array, never reset
  always_ff @(posedge pad_core_clk) begin
    if (commit_c) begin
      mem[cur_idx_q] <= wmerge_c;
    end
  end

  // Transfer FSM with registered bus responses and counters
  always_ff @(posedge pad_core_clk or negedge pad_core_rst_b) begin
    if (!pad_core_rst_b) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      hready_q  <= 1'b1;
      hresp_q   <= 2'b00;
      hrdata_q  <= 32'd0;
      rd_cnt_q  <= 16'd0;
      wr_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
      cur_wr_q  <= 1'b0;
      cur_idx_q <= '0;
      cur_be_q  <= 4'b0000;
    end else begin
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
      hrdata_q <= 32'd0;

      if (state_q == S_DONE) begin
        if (cur_wr_q) begin
          wr_cnt_q <= 16'(wr_cnt_q + 16'd1);
        end else begin
          rd_cnt_q <= 16'(rd_cnt_q + 16'd1);
        end
      end
      if (state_q == S_ERR2) begin
        err_cnt_q <= 16'(err_cnt_q + 16'd1);
      end

      case (state_q)
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_DONE;
            if (!cur_wr_q) begin
              hrdata_q <= mem[cur_idx_q];
            end
          end else begin
            cnt_q    <= 4'(cnt_q - 4'd1);
            hready_q <= 1'b0;
          end
        end
        S_ERR1: begin
          state_q <= S_ERR2;
          hresp_q <= 2'b01;
        end
        default: begin
          if (capture_c) begin
            cur_wr_q  <= cpu_hmain0_m0_hwrite;
            cur_idx_q <= idx_c;
            cur_be_q  <= be_c;
            if (!legal_c) begin
              state_q  <= S_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 2'b01;
            end else if (WAIT_CYC != 0) begin
              state_q  <= S_WAIT;
              cnt_q    <= 4'(WAIT_CYC - 1);
              hready_q <= 1'b0;
            end else begin
              state_q <= S_DONE;
              if (!cpu_hmain0_m0_hwrite) begin
                hrdata_q <= fwd_rdata_c;
              end
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign hmain0_cpu_m0_hrdata = hrdata_q;
  assign hmain0_cpu_m0_hready = hready_q;
  assign hmain0_cpu_m0_hresp  = hresp_q;
  assign rd_cnt               = rd_cnt_q;
  assign wr_cnt               = wr_cnt_q;
  assign err_cnt              = err_cnt_q;

endmodule

// File: tb/tb_tb_ahb_mem_slave.sv
// Directed bench: a zero-wait instance and a three-wait-state instance.
module tb_tb_ahb_mem_slave;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic clk;
  logic rst_n;

  logic [31:0] a_haddr, a_hwdata, a_hrdata;
  logic [2:0]  a_hsize;
  logic [1:0]  a_htrans, a_hresp;
  logic        a_hwrite, a_hready;
  logic [15:0] a_rd, a_wr, a_err;

  logic [31:0] b_haddr, b_hwdata, b_hrdata;
  logic [2:0]  b_hsize;
  logic [1:0]  b_htrans, b_hresp;
  logic        b_hwrite, b_hready;
  logic [15:0] b_rd, b_wr, b_err;

  int tests;
  int fails;

  tb_ahb_mem_slave #(.BASE_ADDR(BASE), .DEPTH(16), .WAIT_CYC(0)) u_dut0 (
    .pad_core_clk(clk), .pad_core_rst_b(rst_n),
    .cpu_hmain0_m0_haddr(a_haddr), .cpu_hmain0_m0_hburst(3'b000),
    .cpu_hmain0_m0_hprot(4'b0011), .cpu_hmain0_m0_hsize(a_hsize),
    .cpu_hmain0_m0_htrans(a_htrans), .cpu_hmain0_m0_hwdata(a_hwdata),
    .cpu_hmain0_m0_hwrite(a_hwrite), .hmain0_cpu_m0_hrdata(a_hrdata),
    .hmain0_cpu_m0_hready(a_hready), .hmain0_cpu_m0_hresp(a_hresp),
    .rd_cnt(a_rd), .wr_cnt(a_wr), .err_cnt(a_err)
  );

  tb_ahb_mem_slave #(.BASE_ADDR(BASE), .DEPTH(16), .WAIT_CYC(3)) u_dut3 (
    .pad_core_clk(clk), .pad_core_rst_b(rst_n),
    .cpu_hmain0_m0_haddr(b_haddr), .cpu_hmain0_m0_hburst(3'b000),
    .cpu_hmain0_m0_hprot(4'b0011), .cpu_hmain0_m0_hsize(b_hsize),
    .cpu_hmain0_m0_htrans(b_htrans), .cpu_hmain0_m0_hwdata(b_hwdata),
    .cpu_hmain0_m0_hwrite(b_hwrite), .hmain0_cpu_m0_hrdata(b_hrdata),
    .hmain0_cpu_m0_hready(b_hready), .hmain0_cpu_m0_hresp(b_hresp),
    .rd_cnt(b_rd), .wr_cnt(b_wr), .err_cnt(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                        input logic [31:0] addr);
    a_htrans = tr; a_hwrite = wr; a_hsize = sz; a_haddr = addr;
  endtask

  task automatic b_beat(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                        input logic [31:0] addr);
    b_htrans = tr; b_hwrite = wr; b_hsize = sz; b_haddr = addr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_beat(2'b00, 1'b0, 3'd2, BASE); a_hwdata = 32'd0;
    b_beat(2'b00, 1'b0, 3'd2, BASE); b_hwdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++; if (a_hready !== 1'b1) begin fails++; $display("FAIL reset_hready got %b exp 1", a_hready); end
    tests++; if (a_hresp !== 2'b00) begin fails++; $display("FAIL reset_hresp got %b exp 00", a_hresp); end
    tests++; if (a_hrdata !== 32'd0) begin fails++; $display("FAIL reset_hrdata got %h exp 0", a_hrdata); end
    tests++; if ({a_rd, a_wr, a_err} !== 48'd0) begin fails++; $display("FAIL reset_counters got %h exp 0", {a_rd, a_wr, a_err}); end
    tests++; if (b_hready !== 1'b1) begin fails++; $display("FAIL reset_hready_w3 got %b exp 1", b_hready); end
  endtask

  task automatic test_raw_forward();
    a_beat(2'b10, 1'b1, 3'd2, BASE + 32'h10);
    tick();
    tests++; if (a_hready !== 1'b1) begin fails++; $display("FAIL raw_wr_hready got %b exp 1", a_hready); end
    a_beat(2'b10, 1'b0, 3'd2, BASE + 32'h10);
    a_hwdata = 32'hDEAD_BEEF;
    tick();
    tests++; if (a_hrdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL raw_fwd_data got %h exp deadbeef", a_hrdata); end
    tests++; if ({a_hready, a_hresp} !== 3'b100) begin fails++; $display("FAIL raw_rd_resp got %b exp 100", {a_hready, a_hresp}); end
    a_beat(2'b00, 1'b0, 3'd2, BASE);
    a_hwdata = 32'd0;
    tick();
    tests++; if ({a_wr, a_rd} !== {16'd1, 16'd1}) begin fails++; $display("FAIL raw_counts got wr=%0d rd=%0d exp 1 1", a_wr, a_rd); end
    tests++; if (a_hrdata !== 32'd0) begin fails++; $display("FAIL raw_idle_data got %h exp 0", a_hrdata); end
  endtask

  task automatic test_byte_half();
    a_beat(2'b10, 1'b1, 3'd0, BASE + 32'h11);
    tick();
    a_beat(2'b10, 1'b1, 3'd1, BASE + 32'h12);
    a_hwdata = 32'h5A5A_5A5A;
    tick();
    a_beat(2'b10, 1'b0, 3'd2, BASE + 32'h10);
    a_hwdata = 32'h1234_FFFF;
    tick();
    a_beat(2'b00, 1'b0, 3'd2, BASE);
    a_hwdata = 32'd0;
    tests++; if (a_hrdata !== 32'h1234_5AEF) begin fails++; $display("FAIL lanes_fwd got %h exp 12345aef", a_hrdata); end
    tick();
    tests++; if ({a_wr, a_rd} !== {16'd3, 16'd2}) begin fails++; $display("FAIL lanes_counts got wr=%0d rd=%0d exp 3 2", a_wr, a_rd); end
    a_beat(2'b10, 1'b0, 3'd2, BASE + 32'h10);
    tick();
    a_beat(2'b00, 1'b0, 3'd2, BASE);
    tests++; if (a_hrdata !== 32'h1234_5AEF) begin fails++; $display("FAIL lanes_mem got %h exp 12345aef", a_hrdata); end
    tick();
    a_beat(2'b01, 1'b1, 3'd2, BASE + 32'h10);
    a_hwdata = 32'hFFFF_FFFF;
    tick();
    tests++; if ({a_hready, a_hresp, a_hrdata} !== {3'b100, 32'd0}) begin fails++; $display("FAIL busy_resp got %h exp 400000000", {a_hready, a_hresp, a_hrdata}); end
    a_beat(2'b00, 1'b0, 3'd2, BASE);
    tick();
    tests++; if (a_wr !== 16'd3) begin fails++; $display("FAIL busy_no_write got wr=%0d exp 3", a_wr); end
  endtask

  task automatic test_error();
    a_beat(2'b10, 1'b1, 3'd2, BASE);
    tick();
    a_beat(2'b00, 1'b0, 3'd2, BASE);
    a_hwdata = 32'h1111_1111;
    tick();
    a_beat(2'b10, 1'b0, 3'd2, BASE + 32'h40);
    tick();
    a_beat(2'b00, 1'b0, 3'd2, BASE);
    tests++; if ({a_hready, a_hresp, a_hrdata} !== {3'b001, 32'd0}) begin fails++; $display("FAIL err1_oob got %h exp 100000000", {a_hready, a_hresp, a_hrdata}); end
    tick();
    tests++; if ({a_hready, a_hresp} !== 3'b101) begin fails++; $display("FAIL err2_oob got %b exp 101", {a_hready, a_hresp}); end
    a_beat(2'b10, 1'b1, 3'd2, BASE + 32'h02);
    tick();
    a_beat(2'b00, 1'b0, 3'd2, BASE);
    a_hwdata = 32'hFFFF_FFFF;
    tests++; if ({a_hready, a_hresp} !== 3'b001) begin fails++; $display("FAIL err1_misalign got %b exp 001", {a_hready, a_hresp}); end
    tick();
    tests++; if ({a_hready, a_hresp} !== 3'b101) begin fails++; $display("FAIL err2_misalign got %b exp 101", {a_hready, a_hresp}); end
    tick();
    tests++; if ({a_err, a_wr, a_rd} !== {16'd2, 16'd4, 16'd3}) begin fails++; $display("FAIL err_counts got err=%0d wr=%0d rd=%0d exp 2 4 3", a_err, a_wr, a_rd); end
    a_beat(2'b10, 1'b0, 3'd2, BASE);
    tick();
    a_beat(2'b00, 1'b0, 3'd2, BASE);
    tests++; if (a_hrdata !== 32'h1111_1111) begin fails++; $display("FAIL err_mem_kept got %h exp 11111111", a_hrdata); end
    tick();
  endtask

  task automatic test_wait_states();
    b_beat(2'b10, 1'b1, 3'd2, BASE + 32'h20);
    tick();
    b_beat(2'b00, 1'b0, 3'd2, BASE);
    b_hwdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      tests++; if ({b_hready, b_hresp} !== 3'b000) begin fails++; $display("FAIL wait_wr_low%0d got %b exp 000", i, {b_hready, b_hresp}); end
      tick();
    end
    tests++; if ({b_hready, b_hresp} !== 3'b100) begin fails++; $display("FAIL wait_wr_done got %b exp 100", {b_hready, b_hresp}); end
    b_beat(2'b10, 1'b0, 3'd2, BASE + 32'h20);
    tick();
    b_beat(2'b00, 1'b0, 3'd2, BASE);
    b_hwdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      tests++; if ({b_hready, b_hrdata} !== 33'd0) begin fails++; $display("FAIL wait_rd_low%0d got %h exp 0", i, {b_hready, b_hrdata}); end
      tick();
    end
    tests++; if ({b_hready, b_hresp, b_hrdata} !== {3'b100, 32'hCAFE_F00D}) begin fails++; $display("FAIL wait_rd_done got %h exp 4cafef00d", {b_hready, b_hresp, b_hrdata}); end
    tick();
    tests++; if ({b_wr, b_rd} !== {16'd1, 16'd1}) begin fails++; $display("FAIL wait_counts got wr=%0d rd=%0d exp 1 1", b_wr, b_rd); end
  endtask

  task automatic test_reset_in_wait();
    b_beat(2'b10, 1'b1, 3'd2, BASE + 32'h20);
    tick();
    b_beat(2'b00, 1'b0, 3'd2, BASE);
    b_hwdata = 32'h5555_5555;
    tick();
    rst_n = 1'b0;
    #1;
    tests++; if ({b_hready, b_hresp, b_hrdata} !== {3'b100, 32'd0}) begin fails++; $display("FAIL rstwait_outputs got %h exp 400000000", {b_hready, b_hresp, b_hrdata}); end
    tests++; if (b_rd !== 16'd0) begin fails++; $display("FAIL rstwait_counter got %0d exp 0", b_rd); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    b_beat(2'b10, 1'b0, 3'd2, BASE + 32'h20);
    tick();
    b_beat(2'b00, 1'b0, 3'd2, BASE);
    repeat (3) tick();
    tests++; if (b_hrdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL rstwait_mem_kept got %h exp cafef00d", b_hrdata); end
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_raw_forward();
    test_byte_half();
    test_error();
    test_wait_states();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
